genius_control: RTL
===================

GENIUS_CONTROL -- requirements
Module: genius_control

Interface
REQ-001 CLOCK_50  input  1  system clock; all state updates on its rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 enter  input  1  active-high player "enter" request (inverted KEY[0]).
REQ-004 end_FPGA  input  1  datapath status: FPGA sequence display finished for the current round.
REQ-005 end_User  input  1  datapath status: player has entered as many buttons as the current round.
REQ-006 end_time  input  1  datapath status: play timer expired.
REQ-007 win  input  1  datapath status: final round reached.
REQ-008 match  input  1  datapath status: user sequence equals FPGA sequence.
REQ-009 R1  output  1  setup/round/clock-divider reset to datapath.
REQ-010 R2  output  1  per-round reset (timer, user, FPGA counters and registers).
REQ-011 E1  output  1  setup register load enable.
REQ-012 E2  output  1  play enable (timer and user input).
REQ-013 E3  output  1  FPGA sequence enable.
REQ-014 E4  output  1  round counter increment enable.
REQ-015 SEL  output  1  display select: 0 = game view (level/time/round), 1 = result view (FPGA/USEr + points).
REQ-016 state_o  output  3  current state encoding, for debug LEDs.

Function
REQ-017 The FSM SHALL be Moore with state held in a 3-bit register and the outputs decoded from that register only.
REQ-018 The states SHALL use these encodings: INIT=0, SETUP=1, PREP=2, SEQ=3, PLAY=4, CHECK=5, NEXT=6, RESULT=7.
REQ-019 Per state, the only asserted outputs SHALL be: INIT R1,R2; SETUP E1; PREP R2; SEQ E3; PLAY E2; CHECK none; NEXT E4; RESULT SEL.
REQ-020 INIT SHALL move to SETUP unconditionally after one cycle.
REQ-021 SETUP SHALL move to PREP on an enter event; otherwise it SHALL hold.
REQ-022 PREP SHALL move to SEQ unconditionally after one cycle.
REQ-023 SEQ SHALL move to PLAY when end_FPGA=1; otherwise it SHALL hold.
REQ-024 PLAY SHALL move to CHECK when end_User=1 or end_time=1; when both are high in the same cycle, the transition SHALL still be to CHECK.
REQ-025 CHECK SHALL move to RESULT when end_time=1, match=0 or win=1; otherwise it SHALL move to NEXT.
REQ-026 In CHECK, end_time=1 SHALL take priority over match=1.
REQ-027 NEXT SHALL hold for exactly one cycle, so E4 is a single-cycle pulse, and SHALL then move to PREP.
REQ-028 RESULT SHALL move to INIT on an enter event; otherwise it SHALL hold.
REQ-029 An enter event occurring in any state other than SETUP and RESULT SHALL be ignored.
REQ-030 An unused or illegal state value SHALL not exist with 3 bits; a default branch SHALL nonetheless return to INIT.

Reset
REQ-031 When reset=1, the state SHALL become INIT immediately (asynchronously), regardless of the current state, including mid-PLAY or mid-SEQ.
REQ-032 While reset is held, the outputs SHALL be R1=1, R2=1, E1=E2=E3=E4=0, SEL=0, state_o=0.
REQ-033 All synchronizer and edge-detect flops SHALL reset to 0.
REQ-034 After reset is released, the FSM SHALL spend exactly one clock cycle in INIT before entering SETUP.

Configuration
REQ-035 With ENTER_SYNC_EN defined, enter SHALL pass through a 2-flop synchronizer and a rising-edge detector.
REQ-036 With ENTER_SYNC_EN defined, an enter event SHALL be a one-cycle pulse, 2 cycles after the input rises, with one event per press regardless of hold length.
REQ-037 With ENTER_SYNC_EN defined, a press held from SETUP through SEQ/PLAY/CHECK SHALL NOT generate an event in RESULT.
REQ-038 Without ENTER_SYNC_EN, an enter event SHALL be enter=1 sampled directly with zero added latency.
REQ-039 Without ENTER_SYNC_EN, a held enter SHALL be seen every cycle.

Verification
REQ-040 Reset mid-PLAY: drive reset=1 -> state_o=0, R1=R2=1 in the same cycle without waiting for a clock; one cycle after release, state_o=1.
REQ-041 Full winning round: enter pulse in SETUP -> PREP(1 cycle), SEQ, then end_FPGA=1 -> PLAY, then end_User=1 with match=1, win=0 -> CHECK, NEXT with a single E4 pulse, then PREP.
REQ-042 Timeout: in PLAY drive end_time=1 and match=1 together -> CHECK then RESULT, SEL=1; enter -> INIT.
REQ-043 Mismatch: end_User=1 with match=0 -> RESULT; with end_User=1, match=1, win=1 -> RESULT.
REQ-044 With ENTER_SYNC_EN defined: hold enter high for 20 cycles in SETUP -> exactly one transition, PREP entered 2 cycles after the rise, and no transition out of RESULT without a new press.
REQ-045 Ignored input: an enter event during SEQ or PLAY -> no change of state_o.

Source files
------------

// File: rtl/genius_control.sv
// Moore control FSM for the Genius memory game: sequences setup, FPGA display, player input, checking and result.
// Optional ENTER_SYNC_EN: enter passes through a 2-flop synchronizer and rising-edge detector.
module genius_control (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       enter,
    input  logic       end_FPGA,
    input  logic       end_User,
    input  logic       end_time,
    input  logic       win,
    input  logic       match,
    output logic       R1,
    output logic       R2,
    output logic       E1,
    output logic       E2,
    output logic       E3,
    output logic       E4,
    output logic       SEL,
    output logic [2:0] state_o
);

    localparam logic [2:0] ST_INIT   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_PREP   = 3'd2;
    localparam logic [2:0] ST_SEQ    = 3'd3;
    localparam logic [2:0] ST_PLAY   = 3'd4;
    localparam logic [2:0] ST_CHECK  = 3'd5;
    localparam logic [2:0] ST_NEXT   = 3'd6;
    localparam logic [2:0] ST_RESULT = 3'd7;

    logic [2:0] state_reg;
    logic [2:0] state_next;
    logic       enter_evt;

`ifdef ENTER_SYNC_EN
    logic sync1_reg;
    logic sync2_reg;
    logic prev_reg;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
        end else begin
            sync1_reg <= enter;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    // One pulse per press: a held button never re-triggers.
    assign enter_evt = sync2_reg & ~prev_reg;
`else
    assign enter_evt = enter;
`endif

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_reg <= ST_INIT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_INIT:   state_next = ST_SETUP;
            ST_SETUP:  if (enter_evt) state_next = ST_PREP;
            ST_PREP:   state_next = ST_SEQ;
            ST_SEQ:    if (end_FPGA) state_next = ST_PLAY;
            ST_PLAY:   if (end_User || end_time) state_next = ST_CHECK;
            // A timeout loses even when the partial sequence matched.
            ST_CHECK:  if (end_time || !match || win) state_next = ST_RESULT;
                       else state_next = ST_NEXT;
            ST_NEXT:   state_next = ST_PREP;
            ST_RESULT: if (enter_evt) state_next = ST_INIT;
            default:   state_next = ST_INIT;
        endcase
    end

    always_comb begin
        R1  = 1'b0;
        R2  = 1'b0;
        E1  = 1'b0;
        E2  = 1'b0;
        E3  = 1'b0;
        E4  = 1'b0;
        SEL = 1'b0;
        case (state_reg)
            ST_INIT:   begin R1 = 1'b1; R2 = 1'b1; end
            ST_SETUP:  E1  = 1'b1;
            ST_PREP:   R2  = 1'b1;
            ST_SEQ:    E3  = 1'b1;
            ST_PLAY:   E2  = 1'b1;
            ST_CHECK:  ;
            ST_NEXT:   E4  = 1'b1;
            ST_RESULT: SEL = 1'b1;
            default:   begin R1 = 1'b1; R2 = 1'b1; end
        endcase
    end

    assign state_o = state_reg;

endmodule
